// File: rtl/student_led_afterglow.sv
// Afterglow output stage: lit LEDs jump to full brightness, dark LEDs fade out
// linearly on a prescaled tick, and each channel is driven through 8-bit PWM.
module student_led_afterglow #(
  parameter int NumLeds = 8,
  parameter int PrescW  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [NumLeds-1:0] led_i,
  input  logic [PrescW-1:0]  fade_div_i,
  input  logic [7:0]         decay_i,
  output logic [NumLeds-1:0] led_o,
  output logic               fade_tick_o
);

  logic [PrescW-1:0]  presc_q, presc_d;
  logic [7:0]         pwm_cnt_q, pwm_cnt_d;
  logic [7:0]         bright_q [NumLeds];
  logic [7:0]         bright_d [NumLeds];
  logic [NumLeds-1:0] led_q, led_d;
  logic               fade_tick;

  // The >= compare keeps a lowered terminal value from being skipped mid-count.
  always_comb begin
    fade_tick = en_i & (presc_q >= fade_div_i);
    presc_d   = '0;
    pwm_cnt_d = '0;
    if (en_i) begin
      pwm_cnt_d = pwm_cnt_q + 8'd1;
      if (!fade_tick) begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Relight wins over a fade tick; the decrement saturates at zero.
  always_comb begin
    for (int i = 0; i < NumLeds; i++) begin
      bright_d[i] = bright_q[i];
      led_d[i]    = en_i & ((bright_q[i] == 8'hFF) | (bright_q[i] > pwm_cnt_q));
      if (!en_i) begin
        bright_d[i] = '0;
      end else if (led_i[i]) begin
        bright_d[i] = 8'hFF;
      end else if (fade_tick) begin
        bright_d[i] = (bright_q[i] > decay_i) ? (bright_q[i] - decay_i) : 8'd0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
      for (int i = 0; i < NumLeds; i++) begin
        bright_q[i] <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
      for (int i = 0; i < NumLeds; i++) begin
        bright_q[i] <= bright_d[i];
      end
    end
  end

  assign led_o       = led_q;
  assign fade_tick_o = fade_tick;

endmodule

// File: tb/tb_student_led_afterglow.sv
// Directed bench for student_led_afterglow: reset, linear fade, PWM duty,
// saturation, relight priority, prescaler retargeting and enable drop.
module tb_student_led_afterglow;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [7:0]  led_i;
  logic [15:0] fade_div_i;
  logic [7:0]  decay_i;
  logic [7:0]  led_o;
  logic        fade_tick_o;

  int checks = 0;
  int errors = 0;

  student_led_afterglow #(.NumLeds(8), .PrescW(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .led_i       (led_i),
    .fade_div_i  (fade_div_i),
    .decay_i     (decay_i),
    .led_o       (led_o),
    .fade_tick_o (fade_tick_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One cycle with en_i low clears all state; en_i is high again on return.
  task automatic clear_state();
    en_i = 1'b0;
    led_i = 8'h00;
    tick();
    en_i = 1'b1;
  endtask

  task automatic test_reset();
    en_i = 1'b1; led_i = 8'hFF; fade_div_i = 16'd5; decay_i = 8'd10;
    repeat (2) tick();
    checks++;
    if (led_o !== 8'h00 || fade_tick_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold led_o=%h tick=%b expected 00/0", led_o, fade_tick_o);
    end
    rst_i = 1'b0;
    repeat (5) tick();
    checks++;
    if (led_o !== 8'hFF) begin
      errors++;
      $display("FAIL reset_prerun led_o=%h expected ff", led_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (led_o !== 8'h00 || fade_tick_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async led_o=%h tick=%b expected 00/0", led_o, fade_tick_o);
    end
    tick();
    rst_i = 1'b0;
    tick();
    checks++;
    if (led_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_edge1 led_o=%h expected 00", led_o);
    end
    tick();
    checks++;
    if (led_o !== 8'hFF) begin
      errors++;
      $display("FAIL reset_edge2 led_o=%h expected ff", led_o);
    end
  endtask

  task automatic test_linear_fade();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'd191; exp_b[1] = 8'd127; exp_b[2] = 8'd63; exp_b[3] = 8'd0;
    fade_div_i = 16'd3; decay_i = 8'd64;
    clear_state();
    led_i = 8'h01;
    tick();
    led_i = 8'h00;
    checks++;
    if (dut.bright_q[0] !== 8'd255) begin
      errors++;
      $display("FAIL fade_lit bright=%0d expected 255", dut.bright_q[0]);
    end
    tick(); tick();
    checks++;
    if (fade_tick_o !== 1'b1 || dut.bright_q[0] !== 8'd255) begin
      errors++;
      $display("FAIL fade_pre_tick tick=%b bright=%0d expected 1/255", fade_tick_o, dut.bright_q[0]);
    end
    tick();
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (dut.bright_q[0] !== exp_b[s]) begin
        errors++;
        $display("FAIL fade_step%0d bright=%0d expected %0d", s, dut.bright_q[0], exp_b[s]);
      end
      if (s < 3) repeat (4) tick();
    end
  endtask

  task automatic test_pwm_duty();
    int ones;
    fade_div_i = 16'd0; decay_i = 8'd64;
    clear_state();
    led_i = 8'h01;
    tick();
    led_i = 8'h00;
    tick();
    decay_i = 8'd0;
    ones = 0;
    for (int c = 0; c < 256; c++) begin
      tick();
      if (led_o[0]) ones++;
    end
    checks++;
    if (ones != 191 || dut.bright_q[0] !== 8'd191) begin
      errors++;
      $display("FAIL pwm_duty high=%0d bright=%0d expected 191/191", ones, dut.bright_q[0]);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'd55; exp_b[1] = 8'd0; exp_b[2] = 8'd0;
    fade_div_i = 16'd0; decay_i = 8'd200;
    clear_state();
    led_i = 8'h01;
    tick();
    led_i = 8'h00;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (dut.bright_q[0] !== exp_b[s]) begin
        errors++;
        $display("FAIL sat_step%0d bright=%0d expected %0d", s, dut.bright_q[0], exp_b[s]);
      end
    end
  endtask

  task automatic test_priority();
    int bad;
    fade_div_i = 16'd0; decay_i = 8'd255;
    clear_state();
    led_i = 8'h08;
    tick(); tick();
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (led_o !== 8'h08 || fade_tick_o !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL priority_hold bad_cycles=%0d expected 0 (led_o=%h)", bad, led_o);
    end
    led_i = 8'h00;
    tick();
    checks++;
    if (dut.bright_q[3] !== 8'd0) begin
      errors++;
      $display("FAIL priority_release bright=%0d expected 0", dut.bright_q[3]);
    end
  endtask

  task automatic test_presc_change();
    int bad;
    fade_div_i = 16'd1000; decay_i = 8'd0;
    clear_state();
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      if (fade_tick_o !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL presc_quiet early_ticks=%0d expected 0", bad);
    end
    fade_div_i = 16'd10;
    #1;
    checks++;
    if (fade_tick_o !== 1'b1) begin
      errors++;
      $display("FAIL presc_wrap tick=%b expected 1", fade_tick_o);
    end
    for (int p = 0; p < 3; p++) begin
      bad = 0;
      for (int c = 1; c < 11; c++) begin
        tick();
        if (fade_tick_o !== 1'b0) bad++;
      end
      tick();
      checks++;
      if (bad != 0 || fade_tick_o !== 1'b1) begin
        errors++;
        $display("FAIL presc_period%0d early=%0d tick=%b expected 0/1", p, bad, fade_tick_o);
      end
    end
  endtask

  task automatic test_enable_drop();
    int bad;
    fade_div_i = 16'd3; decay_i = 8'd64;
    clear_state();
    led_i = 8'h81;
    tick();
    led_i = 8'h00;
    repeat (5) tick();
    checks++;
    if (dut.bright_q[0] !== 8'd191) begin
      errors++;
      $display("FAIL endrop_pre bright=%0d expected 191", dut.bright_q[0]);
    end
    en_i = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i < 8; i++) if (dut.bright_q[i] !== 8'd0) bad++;
    checks++;
    if (led_o !== 8'h00 || fade_tick_o !== 1'b0 || bad != 0) begin
      errors++;
      $display("FAIL endrop_clear led_o=%h tick=%b nonzero_bright=%0d expected 00/0/0", led_o, fade_tick_o, bad);
    end
    en_i = 1'b1;
    #1;
    bad = (fade_tick_o !== 1'b0) ? 1 : 0;
    tick();
    if (fade_tick_o !== 1'b0) bad++;
    tick();
    if (fade_tick_o !== 1'b0) bad++;
    tick();
    checks++;
    if (bad != 0 || fade_tick_o !== 1'b1) begin
      errors++;
      $display("FAIL endrop_first_tick early=%0d tick=%b expected 0/1", bad, fade_tick_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0; led_i = 8'h00; fade_div_i = 16'd0; decay_i = 8'd0;
    test_reset();
    test_linear_fade();
    test_pwm_duty();
    test_saturation();
    test_priority();
    test_presc_change();
    test_enable_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
